// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - command-driven BRAM reader with credit-tracked show-ahead output FIFO
//
// Purpose: accepts (start address, length) commands and reads that many words from one
// BRAM port, presenting them in order on a valid/ready stream with a last flag.
//
// Ports:
//   clk_in, rst_in                      clock, synchronous active-high reset
//   cmd_valid_in / cmd_ready_out        command handshake
//   cmd_addr_in, cmd_len_in             start address, word count (0..RAM_DEPTH)
//   ram_addr_out, ram_en_out            registered BRAM port address and enable
//   ram_regce_out                       BRAM output register enable (constant 1)
//   ram_data_in                         BRAM port dout
//   data_out, data_valid_out,
//   data_ready_in, data_last_out        output word stream (FIFO head)
//   busy_out                            command accepted and not yet fully popped
module bram_stream_reader #(
    parameter int  RAM_WIDTH    = 18,
    parameter int  RAM_DEPTH    = 1024,
    parameter int  READ_LATENCY = 2,
    parameter int  FIFO_DEPTH   = 4,
    localparam int AW           = $clog2(RAM_DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 cmd_valid_in,
    output logic                 cmd_ready_out,
    input  logic [AW-1:0]        cmd_addr_in,
    input  logic [AW:0]          cmd_len_in,
    output logic [AW-1:0]        ram_addr_out,
    output logic                 ram_en_out,
    output logic                 ram_regce_out,
    input  logic [RAM_WIDTH-1:0] ram_data_in,
    output logic [RAM_WIDTH-1:0] data_out,
    output logic                 data_valid_out,
    input  logic                 data_ready_in,
    output logic                 data_last_out,
    output logic                 busy_out
);

    localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  r_state;
    logic [AW-1:0]           r_addr;
    logic [AW:0]             r_remaining;
    logic [AW-1:0]           r_ram_addr;
    logic                    r_ram_en;
    logic                    r_en_last;
    logic                    r_busy;
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_l;

    logic [RAM_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   r_fifo_last;
    logic [FPW-1:0]          r_rd_ptr;
    logic [FPW-1:0]          r_wr_ptr;
    logic [FCW-1:0]          r_count;

    logic                    w_pop;
    logic                    w_push;
    logic                    w_head_last;
    logic [OCW-1:0]          w_occ;
    logic                    w_can_issue;

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a == AW'(RAM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [FPW-1:0] ptr_inc(input logic [FPW-1:0] p);
        return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop       = (r_count != '0) && data_ready_in;
    assign w_push      = r_tag_v[READ_LATENCY-1];
    assign w_head_last = r_fifo_last[r_rd_ptr];

    // Every word already requested holds a FIFO slot: queued, at the BRAM input, or in the
    // read pipeline. A word popped at this edge frees its slot for an issue at the same edge.
    always_comb begin
        w_occ = OCW'(r_count) + OCW'(r_ram_en);
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_occ = w_occ + OCW'(r_tag_v[i]);
        end
        w_can_issue = w_occ < (OCW'(FIFO_DEPTH) + OCW'(w_pop));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_ram_addr  <= '0;
            r_ram_en    <= 1'b0;
            r_en_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_tag_v     <= '0;
            r_tag_l     <= '0;
        end else begin
            // Tags advance unconditionally: the BRAM output register always loads.
            r_tag_v   <= READ_LATENCY'({r_tag_v, r_ram_en});
            r_tag_l   <= READ_LATENCY'({r_tag_l, r_en_last});
            r_ram_en  <= 1'b0;
            r_en_last <= 1'b0;
            case (r_state)
                IDLE: begin
                    // The first read issues at the accept edge itself; the pipeline is empty here.
                    if (cmd_valid_in && cmd_len_in != '0) begin
                        r_ram_en    <= 1'b1;
                        r_ram_addr  <= cmd_addr_in;
                        r_addr      <= addr_inc(cmd_addr_in);
                        r_remaining <= cmd_len_in - 1'b1;
                        r_busy      <= 1'b1;
                        if (cmd_len_in == (AW+1)'(1)) begin
                            r_en_last <= 1'b1;
                            r_state   <= DRAIN;
                        end else begin
                            r_state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (w_can_issue) begin
                        r_ram_en    <= 1'b1;
                        r_ram_addr  <= r_addr;
                        r_addr      <= addr_inc(r_addr);
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (AW+1)'(1)) begin
                            r_en_last <= 1'b1;
                            r_state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && w_head_last) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset so it can map to distributed RAM.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ram_data_in;
            r_fifo_last[r_wr_ptr] <= r_tag_l[READ_LATENCY-1];
        end
    end

    assign cmd_ready_out  = (r_state == IDLE) && !rst_in;
    assign ram_addr_out   = r_ram_addr;
    assign ram_en_out     = r_ram_en;
    assign ram_regce_out  = 1'b1;
    assign data_out       = r_fifo_data[r_rd_ptr];
    assign data_valid_out = (r_count != '0);
    assign data_last_out  = w_head_last;
    assign busy_out       = r_busy;

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - directed self-checking bench for bram_stream_reader
module tb_bram_stream_reader;

    localparam int W  = 18;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          cmd_valid_in = 1'b0;
    logic          cmd_ready_out;
    logic [AW-1:0] cmd_addr_in = '0;
    logic [AW:0]   cmd_len_in = '0;
    logic [AW-1:0] ram_addr_out;
    logic          ram_en_out;
    logic          ram_regce_out;
    logic [W-1:0]  ram_data_in;
    logic [W-1:0]  data_out;
    logic          data_valid_out;
    logic          data_ready_in = 1'b0;
    logic          data_last_out;
    logic          busy_out;

    bram_stream_reader #(
        .RAM_WIDTH(W), .RAM_DEPTH(D), .READ_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_addr_in(cmd_addr_in), .cmd_len_in(cmd_len_in),
        .ram_addr_out(ram_addr_out), .ram_en_out(ram_en_out), .ram_regce_out(ram_regce_out),
        .ram_data_in(ram_data_in),
        .data_out(data_out), .data_valid_out(data_valid_out), .data_ready_in(data_ready_in),
        .data_last_out(data_last_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // BRAM model, HIGH_PERFORMANCE mode: mem[i] = i, two registered read stages.
    logic [W-1:0] mem [D];
    logic [W-1:0] bram_r1 = '0;
    logic [W-1:0] bram_dout = '0;
    initial for (int i = 0; i < D; i++) mem[i] = W'(i);
    always @(posedge clk_in) begin
        if (ram_en_out) bram_r1 <= mem[ram_addr_out];
        if (ram_regce_out) bram_dout <= bram_r1;
    end
    assign ram_data_in = bram_dout;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           cyc;
    } word_t;

    word_t got[$];
    int    addr_q[$];
    int    issues, pops, max_occ, stab_err, first_valid_cyc, valid_seen, busy_seen;
    logic  prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic  prev_last;
    int    n_cmp = 0;
    int    n_err = 0;

    // Monitor on the falling edge: records issues, pops and head stability.
    always @(negedge clk_in) begin
        if (rst_in) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_en_out) begin
                issues++;
                addr_q.push_back(int'(ram_addr_out));
            end
            if (issues - pops > max_occ) max_occ = issues - pops;
            if (data_valid_out) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (busy_out) busy_seen++;
            if (prev_stall && (!data_valid_out || data_out !== prev_data || data_last_out !== prev_last))
                stab_err++;
            prev_stall = data_valid_out && !data_ready_in;
            prev_data  = data_out;
            prev_last  = data_last_out;
            if (data_valid_out && data_ready_in) begin
                got.push_back(word_t'{data_out, data_last_out, cyc});
                pops++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic clear_mon();
        got.delete();
        addr_q.delete();
        issues = 0; pops = 0; max_occ = 0; stab_err = 0;
        first_valid_cyc = -1; valid_seen = 0; busy_seen = 0;
    endtask

    task automatic send_cmd(input int addr, input int len, output int acc_cyc);
        int b = 0;
        while (!cmd_ready_out && b < 50) begin
            step();
            b++;
        end
        check_eq("cmd_ready_before_send", cmd_ready_out, 1);
        cmd_valid_in = 1'b1;
        cmd_addr_in  = AW'(addr);
        cmd_len_in   = (AW+1)'(len);
        step();
        acc_cyc      = cyc;
        cmd_valid_in = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int len, input int budget);
        int b = 0;
        while ((got.size() < len || busy_out) && b < budget) begin
            step();
            b++;
        end
        check_eq({tag, "_in_time"}, (b < budget), 1);
    endtask

    task automatic check_stream(input string tag, input int a0, input int len, input bit consec);
        int errs = 0;
        check_eq({tag, "_count"}, got.size(), len);
        for (int i = 0; i < got.size() && i < len; i++) begin
            if (got[i].data !== W'((a0 + i) % D)) errs++;
            if (got[i].last !== (i == len - 1)) errs++;
            if (consec && got[i].cyc != got[0].cyc + i) errs++;
        end
        check_eq({tag, "_content_errs"}, errs, 0);
    endtask

    initial begin
        int acc;
        int b;
        int aerr;
        clear_mon();

        // Reset state
        step(3);
        check_eq("rst_cmd_ready", cmd_ready_out, 0);
        check_eq("rst_valid", data_valid_out, 0);
        check_eq("rst_ram_en", ram_en_out, 0);
        check_eq("rst_busy", busy_out, 0);
        check_eq("regce_const", ram_regce_out, 1);
        rst_in = 1'b0;
        #1;
        check_eq("cmd_ready_after_rst", cmd_ready_out, 1);

        // Basic read
        data_ready_in = 1'b1;
        clear_mon();
        send_cmd(16, 4, acc);
        wait_done("basic", 4, 50);
        check_eq("basic_cmd_ready_after_last", cmd_ready_out, 1);
        check_eq("basic_latency", first_valid_cyc - acc, 3);
        check_stream("basic", 16, 4, 1'b1);

        // Wrap-around
        clear_mon();
        send_cmd(1022, 4, acc);
        wait_done("wrap", 4, 50);
        check_stream("wrap", 1022, 4, 1'b1);
        aerr = 0;
        for (int i = 0; i < addr_q.size() && i < 4; i++)
            if (addr_q[i] != (1022 + i) % D) aerr++;
        check_eq("wrap_addr_count", addr_q.size(), 4);
        check_eq("wrap_addr_errs", aerr, 0);

        // Backpressure
        data_ready_in = 1'b0;
        clear_mon();
        send_cmd(0, 16, acc);
        step(10);
        check_eq("bp_stall_issues", issues, 4);
        check_eq("bp_head_valid", data_valid_out, 1);
        check_eq("bp_head_data", data_out, 0);
        b = 0;
        while ((got.size() < 16 || busy_out) && b < 200) begin
            data_ready_in = ~data_ready_in;
            step();
            b++;
        end
        check_eq("bp_in_time", (b < 200), 1);
        data_ready_in = 1'b1;
        check_stream("bp", 0, 16, 1'b0);
        check_eq("bp_max_occ", max_occ, 4);
        check_eq("bp_head_stable_errs", stab_err, 0);

        // Zero length
        clear_mon();
        send_cmd(5, 0, acc);
        check_eq("zero_cmd_ready_next", cmd_ready_out, 1);
        step(6);
        check_eq("zero_issues", issues, 0);
        check_eq("zero_valid_seen", valid_seen, 0);
        check_eq("zero_busy_seen", busy_seen, 0);

        // Reset mid-stream
        clear_mon();
        send_cmd(0, 32, acc);
        b = 0;
        while (got.size() < 5 && b < 100) begin
            step();
            b++;
        end
        check_eq("rst_mid_popped5", got.size(), 5);
        rst_in = 1'b1;
        step();
        check_eq("rst_mid_valid", data_valid_out, 0);
        check_eq("rst_mid_ram_en", ram_en_out, 0);
        check_eq("rst_mid_busy", busy_out, 0);
        step();
        rst_in = 1'b0;
        clear_mon();
        send_cmd(256, 2, acc);
        wait_done("post_rst", 2, 50);
        step(10);
        check_stream("post_rst", 256, 2, 1'b1);

        // Full depth
        clear_mon();
        send_cmd(0, 1024, acc);
        wait_done("full", 1024, 1200);
        check_stream("full", 0, 1024, 1'b1);
        check_eq("full_issues", issues, 1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
